// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - shared constants and types for the data bus responder
// Contents: address map constants, FSM state enum, address region enum,
// blank segment pattern and the address decode helper.
package data_bus_pkg;

  localparam int DATA_W    = 16;
  localparam int HEX_COUNT = 6;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] LEDR_ADDR = 16'h1000;
  localparam logic [15:0] HEX_BASE  = 16'h2000;
  localparam logic [15:0] SW_ADDR   = 16'h3000;
  localparam logic [15:0] KEY_ADDR  = 16'h3001;

  localparam logic [6:0] HEX_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    RG_RAM  = 3'd0,
    RG_LEDR = 3'd1,
    RG_HEX  = 3'd2,
    RG_SW   = 3'd3,
    RG_KEY  = 3'd4,
    RG_NONE = 3'd5
  } region_e;

  // Map a word address onto the region that serves it.
  function automatic region_e decode_addr(input logic [15:0] a, input int depth);
    region_e r;
    if (int'(a - RAM_BASE) < depth)                                 r = RG_RAM;
    else if (a == LEDR_ADDR)                                        r = RG_LEDR;
    else if (a >= HEX_BASE && a < HEX_BASE + 16'(HEX_COUNT))        r = RG_HEX;
    else if (a == SW_ADDR)                                          r = RG_SW;
    else if (a == KEY_ADDR)                                         r = RG_KEY;
    else                                                            r = RG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port synchronous data RAM with registered read
// Ports:
//   clk    in   clock
//   we     in   write enable
//   addr   in   word address (shared by read and write)
//   wdata  in   write data
//   q      out  registered read data of addr at the last edge
module data_ram
  import data_bus_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - memory-side responder for the processor data port
// Ports:
//   Clock, Reset         clock; asynchronous active-high reset
//   DataAddr, DataOut    word address / write data from processor
//   WriteData, ReadData  request strobes (write wins when both set)
//   DataIn               read data to processor, held until the next read completes
//   DataWaitreq          stall; processor holds its request while high
//   SW, KEY              switches / pushbuttons (double-flop synchronized)
//   LEDR, HEX0..HEX5     output registers (HEX active-low)
//   BusErr               pulse in the completing cycle of an unmapped access
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int RAM_DEPTH = 4096,
  parameter int RD_WAIT   = 1,
  parameter int WR_WAIT   = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] DataAddr,
  input  logic [15:0] DataOut,
  input  logic        WriteData,
  input  logic        ReadData,
  output logic [15:0] DataIn,
  output logic        DataWaitreq,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  output logic [9:0]  LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        BusErr
);

  localparam int AW   = $clog2(RAM_DEPTH);
  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = $clog2(MAXW + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   load;
  logic            op_wr_q;
  logic [15:0]     addr_q;
  logic [15:0]     data_q;
  region_e         region_q;

  logic [9:0]      sw_s1, sw_s2;
  logic [3:0]      key_s1, key_s2;
  logic [9:0]      ledr_q;
  logic [6:0]      hex_q [HEX_COUNT];
  logic [15:0]     din_q;
  logic [15:0]     io_q;
  logic [15:0]     io_rd;
  logic [15:0]     ram_q;
  logic [15:0]     rd_done;

  logic            req;
  logic            in_idle;
  logic            zero_wr;
  logic            commit;
  logic            ram_we;
  logic [15:0]     a_eff;
  logic [15:0]     d_eff;
  region_e         region_eff;
  logic [2:0]      hex_idx;
  logic [AW-1:0]   ram_addr;

  assign req     = WriteData | ReadData;
  assign in_idle = (state == IDLE);

  // While idle the live bus is the transfer being started; afterwards the
  // latched copy is authoritative so DataAddr changes during WAIT are ignored.
  assign a_eff      = in_idle ? DataAddr : addr_q;
  assign d_eff      = in_idle ? DataOut  : data_q;
  assign region_eff = in_idle ? decode_addr(DataAddr, RAM_DEPTH) : region_q;
  assign hex_idx    = 3'(a_eff - HEX_BASE);
  assign ram_addr   = a_eff[AW-1:0];

  // A zero-wait write completes in its own request cycle without leaving IDLE.
  assign zero_wr = in_idle & WriteData & (WR_WAIT == 0);
  assign commit  = ~Reset & (zero_wr | ((state == DONE) & op_wr_q));
  assign ram_we  = commit & (region_eff == RG_RAM);

  assign load = WriteData ? CW'(WR_WAIT) : CW'(RD_WAIT);

  assign DataWaitreq = req & (state != DONE) & ~zero_wr;
  assign BusErr      = ((state == DONE) | (zero_wr & ~Reset)) & (region_eff == RG_NONE);

  // RAM data comes out of the RAM's own read register; I/O data out of io_q.
  // Both were captured on the edge that entered DONE.
  assign rd_done = (region_q == RG_RAM) ? ram_q : io_q;
  assign DataIn  = ((state == DONE) & ~op_wr_q) ? rd_done : din_q;

  assign LEDR = ledr_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

  data_ram #(
    .DEPTH (RAM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (Clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (d_eff),
    .q     (ram_q)
  );

  always_comb begin
    io_rd = 16'h0000;
    case (region_eff)
      RG_LEDR: io_rd = {6'b0, ledr_q};
      RG_HEX:  io_rd = {9'b0, hex_q[hex_idx]};
      RG_SW:   io_rd = {6'b0, sw_s2};
      RG_KEY:  io_rd = {12'b0, key_s2};
      default: io_rd = 16'h0000;
    endcase
  end

  // Transfer FSM. cnt holds the stall cycles still to come while in WAIT;
  // the request cycle itself already counts as the first stall cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr_q  <= 1'b0;
      addr_q   <= 16'h0000;
      data_q   <= 16'h0000;
      region_q <= RG_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr_q  <= WriteData;
            addr_q   <= DataAddr;
            data_q   <= DataOut;
            region_q <= decode_addr(DataAddr, RAM_DEPTH);
            if (load == CW'(1)) begin
              state <= DONE;
            end else if (load != '0) begin
              cnt   <= load - CW'(1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req) begin
            // Processor withdrew mid-transfer: abandon without committing.
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
      ledr_q <= '0;
      din_q  <= 16'h0000;
      io_q   <= 16'h0000;
      for (int i = 0; i < HEX_COUNT; i++) hex_q[i] <= HEX_BLANK;
    end else begin
      sw_s1  <= SW;
      sw_s2  <= sw_s1;
      key_s1 <= KEY;
      key_s2 <= key_s1;
      io_q   <= io_rd;
      if ((state == DONE) && !op_wr_q) din_q <= rd_done;
      if (commit) begin
        case (region_eff)
          RG_LEDR: ledr_q <= d_eff[9:0];
          RG_HEX:  hex_q[hex_idx] <= d_eff[6:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - self-checking bench for data_bus_responder
module tb_data_bus_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic [15:0] addr   [2];
  logic [15:0] dout   [2];
  logic [15:0] din    [2];
  logic        wr     [2];
  logic        rd     [2];
  logic        wait_s [2];
  logic        berr   [2];
  logic [9:0]  sw     [2];
  logic [3:0]  key    [2];
  logic [9:0]  ledr   [2];
  logic [6:0]  hex    [2][6];

  int rd_lat [2] = '{2, 3};
  int wr_lat [2] = '{1, 4};

  int n_vec = 0;
  int n_bad = 0;

  data_bus_responder #(.RAM_DEPTH(4096), .RD_WAIT(1), .WR_WAIT(0)) u_dut (
    .Clock(clk), .Reset(rst[0]), .DataAddr(addr[0]), .DataOut(dout[0]),
    .WriteData(wr[0]), .ReadData(rd[0]), .DataIn(din[0]), .DataWaitreq(wait_s[0]),
    .SW(sw[0]), .KEY(key[0]), .LEDR(ledr[0]),
    .HEX0(hex[0][0]), .HEX1(hex[0][1]), .HEX2(hex[0][2]),
    .HEX3(hex[0][3]), .HEX4(hex[0][4]), .HEX5(hex[0][5]), .BusErr(berr[0])
  );

  data_bus_responder #(.RAM_DEPTH(4096), .RD_WAIT(2), .WR_WAIT(3)) u_dut_slow (
    .Clock(clk), .Reset(rst[1]), .DataAddr(addr[1]), .DataOut(dout[1]),
    .WriteData(wr[1]), .ReadData(rd[1]), .DataIn(din[1]), .DataWaitreq(wait_s[1]),
    .SW(sw[1]), .KEY(key[1]), .LEDR(ledr[1]),
    .HEX0(hex[1][0]), .HEX1(hex[1][1]), .HEX2(hex[1][2]),
    .HEX3(hex[1][3]), .HEX4(hex[1][4]), .HEX5(hex[1][5]), .BusErr(berr[1])
  );

  typedef struct {
    bit          we;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
    bit          err;
  } vec_t;

  vec_t tbl [$];

  // Transaction-level model of device 0.
  logic [15:0] mem_m [int];
  logic [9:0]  ledr_m;
  logic [6:0]  hex_m [6];
  logic [15:0] last_din [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_unmapped(input logic [15:0] a);
    return !(a < 16'h1000 || a == 16'h1000 || (a >= 16'h2000 && a <= 16'h2005) ||
             a == 16'h3000 || a == 16'h3001);
  endfunction

  function automatic logic [15:0] model_value(input logic [15:0] a);
    if (a < 16'h1000)                     return mem_m.exists(int'(a)) ? mem_m[int'(a)] : 16'h0000;
    if (a == 16'h1000)                    return {6'b0, ledr_m};
    if (a >= 16'h2000 && a <= 16'h2005)   return {9'b0, hex_m[int'(a) - 'h2000]};
    if (a == 16'h3000)                    return {6'b0, sw[0]};
    if (a == 16'h3001)                    return {12'b0, key[0]};
    return 16'h0000;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [15:0] d);
    if (a < 16'h1000)                         mem_m[int'(a)] = d;
    else if (a == 16'h1000)                   ledr_m = d[9:0];
    else if (a >= 16'h2000 && a <= 16'h2005)  hex_m[int'(a) - 'h2000] = d[6:0];
  endtask

  // One complete transfer; returns at the completing cycle with the request
  // still asserted so the next call can follow without a gap.
  task automatic bus_op(input int d, input bit we, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_din, input bit exp_err);
    int          cyc;
    int          errs;
    bit          done;
    bit          last_err;
    logic [15:0] got;
    @(posedge clk); #1;
    addr[d] = a; dout[d] = wd; wr[d] = we; rd[d] = !we;
    cyc = 0; errs = 0; done = 0; last_err = 0; got = 16'hDEAD;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      errs += int'(berr[d]);
      if (!wait_s[d]) begin
        done = 1; got = din[d]; last_err = berr[d];
      end else begin
        @(posedge clk); #1;
      end
    end
    chk($sformatf("latency d%0d a=%h", d, a), cyc, we ? wr_lat[d] : rd_lat[d]);
    chk($sformatf("datain d%0d a=%h", d, a), got, exp_din);
    chk($sformatf("buserr d%0d a=%h", d, a), errs * 2 + int'(last_err), exp_err ? 3 : 0);
  endtask

  task automatic idle(input int d, input int n);
    @(posedge clk); #1;
    wr[d] = 0; rd[d] = 0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    logic [15:0] exp_din;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1; addr[d] = 0; dout[d] = 0; wr[d] = 0; rd[d] = 0;
      sw[d] = 10'h155; key[d] = 4'hA; last_din[d] = 16'h0000;
    end
    ledr_m = 0;
    for (int i = 0; i < 6; i++) hex_m[i] = 7'h7F;

    tbl.push_back('{1, 16'h0010, 16'hBEEF, 16'h0000, 0});
    tbl.push_back('{0, 16'h0010, 16'h0000, 16'hBEEF, 0});
    tbl.push_back('{1, 16'h0020, 16'h1234, 16'h0000, 0});
    tbl.push_back('{0, 16'h0020, 16'h0000, 16'h1234, 0});
    tbl.push_back('{1, 16'h1000, 16'h02A5, 16'h0000, 0});
    tbl.push_back('{1, 16'h2003, 16'h0040, 16'h0000, 0});
    tbl.push_back('{0, 16'h1000, 16'h0000, 16'h02A5, 0});
    tbl.push_back('{0, 16'h2003, 16'h0000, 16'h0040, 0});
    tbl.push_back('{0, 16'h2000, 16'h0000, 16'h007F, 0});
    tbl.push_back('{0, 16'h2005, 16'h0000, 16'h007F, 0});
    tbl.push_back('{0, 16'h3000, 16'h0000, 16'h0155, 0});
    tbl.push_back('{1, 16'h3000, 16'hFFFF, 16'h0000, 0});
    tbl.push_back('{0, 16'h3000, 16'h0000, 16'h0155, 0});
    tbl.push_back('{0, 16'h3001, 16'h0000, 16'h000A, 0});
    tbl.push_back('{0, 16'h4000, 16'h0000, 16'h0000, 1});
    tbl.push_back('{1, 16'h8FFF, 16'h1111, 16'h0000, 1});
    tbl.push_back('{1, 16'h0FFF, 16'h5A5A, 16'h0000, 0});
    tbl.push_back('{0, 16'h0FFF, 16'h0000, 16'h5A5A, 0});
    tbl.push_back('{0, 16'h1001, 16'h0000, 16'h0000, 1});
    tbl.push_back('{0, 16'h2006, 16'h0000, 16'h0000, 1});
    tbl.push_back('{0, 16'h3002, 16'h0000, 16'h0000, 1});
    tbl.push_back('{0, 16'h0010, 16'h0000, 16'hBEEF, 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset datain", din[0], 16'h0000);
    chk("reset ledr", ledr[0], 10'h000);
    chk("reset buserr", berr[0], 1'b0);
    chk("reset waitreq", wait_s[0], 1'b0);
    for (int i = 0; i < 6; i++) chk($sformatf("reset hex%0d", i), hex[0][i], 7'h7F);
    @(posedge clk); #1;
    rst[0] = 0; rst[1] = 0;
    idle(0, 3);

    // Directed table on the fast device, transfers issued back to back.
    for (int i = 0; i < tbl.size(); i++) begin
      exp_din = tbl[i].we ? last_din[0] : tbl[i].exp;
      bus_op(0, tbl[i].we, tbl[i].a, tbl[i].d, exp_din, tbl[i].err);
      if (!tbl[i].we) last_din[0] = tbl[i].exp;
      if (tbl[i].we) model_write(tbl[i].a, tbl[i].d);
    end
    @(negedge clk);
    chk("ledr after writes", ledr[0], 10'h2A5);
    for (int i = 0; i < 6; i++) chk($sformatf("hex%0d after writes", i), hex[0][i], (i == 3) ? 7'h40 : 7'h7F);

    // Randomized transfers checked against the transaction model.
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      bit          we;
      logic [15:0] wd;
      int          pick;
      if ($urandom_range(0, 9) == 0) begin
        idle(0, 1); #1;
        sw[0]  = 10'($urandom);
        key[0] = 4'($urandom);
        repeat (3) @(posedge clk);
      end
      pick = $urandom_range(0, 7);
      case (pick)
        0, 1:    a = 16'($urandom_range(0, 31));
        2:       a = ($urandom_range(0, 1) == 1) ? 16'h0FFF : 16'h0FFE;
        3:       a = 16'h1000;
        4:       a = 16'h2000 + 16'($urandom_range(0, 5));
        5:       a = 16'h3000 + 16'($urandom_range(0, 1));
        6:       a = ($urandom_range(0, 1) == 1) ? 16'h2006 : 16'h1001;
        default: a = 16'($urandom);
      endcase
      we = ($urandom_range(0, 1) == 1);
      wd = 16'($urandom);
      if (!we && a < 16'h1000 && !mem_m.exists(int'(a))) we = 1;
      exp_din = we ? last_din[0] : model_value(a);
      bus_op(0, we, a, wd, exp_din, model_unmapped(a));
      if (we) model_write(a, wd);
      else    last_din[0] = exp_din;
    end
    idle(0, 1);
    @(negedge clk);
    chk("ledr vs model", ledr[0], ledr_m);
    for (int i = 0; i < 6; i++) chk($sformatf("hex%0d vs model", i), hex[0][i], hex_m[i]);

    // Slow device: multi-cycle waits, request withdrawal, reset mid-write.
    bus_op(1, 1, 16'h0005, 16'h1111, 16'h0000, 0);
    bus_op(1, 0, 16'h0005, 16'h0000, 16'h1111, 0);
    bus_op(1, 1, 16'h1000, 16'h03FF, 16'h1111, 0);
    @(negedge clk);
    chk("slow ledr", ledr[1], 10'h3FF);

    @(posedge clk); #1;
    addr[1] = 16'h0005; dout[1] = 16'hCAFE; wr[1] = 1; rd[1] = 0;
    @(negedge clk);
    chk("abort waitreq c0", wait_s[1], 1'b1);
    @(posedge clk); #1;
    addr[1] = 16'h0777;
    @(negedge clk);
    chk("abort waitreq c1", wait_s[1], 1'b1);
    @(posedge clk); #1;
    wr[1] = 0;
    @(negedge clk);
    chk("abort waitreq c2", wait_s[1], 1'b0);
    chk("abort buserr", berr[1], 1'b0);
    bus_op(1, 0, 16'h0005, 16'h0000, 16'h1111, 0);

    @(posedge clk); #1;
    addr[1] = 16'h0005; dout[1] = 16'hCAFE; wr[1] = 1; rd[1] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1; wr[1] = 0;
    @(negedge clk);
    chk("rst waitreq", wait_s[1], 1'b0);
    chk("rst ledr", ledr[1], 10'h000);
    chk("rst datain", din[1], 16'h0000);
    chk("rst buserr", berr[1], 1'b0);
    chk("rst hex0", hex[1][0], 7'h7F);
    @(posedge clk); #1;
    rst[1] = 0;
    idle(1, 2);
    bus_op(1, 0, 16'h0005, 16'h0000, 16'h1111, 0);
    idle(1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
